// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_t;

   localparam int unsigned SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell reused by the serial adder datapath.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around one full_adder cell, LSB first.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sa_state_t        r_state, w_next;
   logic [WIDTH-1:0] r_ra, r_rb, r_rs, r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_carry, r_cout;
   logic             w_s, w_co, w_accept, w_last, w_busy, w_done;

   full_adder u_fa (
      .A    (r_ra[0]),
      .B    (r_rb[0]),
      .Cin  (r_carry),
      .S    (w_s),
      .Cout (w_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_last   = 1'b0;
      w_busy   = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = SHIFT;
            end
         end
         SHIFT: begin
            w_busy = 1'b1;
            if (r_cnt == LAST) begin
               w_last = 1'b1;
               w_next = DONE;
            end
         end
         DONE: begin
            w_done = 1'b1;
            if (start) begin
               w_accept = 1'b1;
               w_next   = SHIFT;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ra    <= '0;
         r_rb    <= '0;
         r_rs    <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_accept) begin
         r_ra    <= A;
         r_rb    <= B;
         r_carry <= Cin;
         r_cnt   <= '0;
      end else if (w_busy) begin
         r_ra    <= r_ra >> 1;
         r_rb    <= r_rb >> 1;
         r_rs    <= {w_s, r_rs[WIDTH-1:1]};
         r_carry <= w_co;
         // cnt holds on the final bit so it never wraps within an operation
         if (!w_last) r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum  <= {w_s, r_rs[WIDTH-1:1]};
            r_cout <= w_co;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   // r_carry at the final bit is the carry into the MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_ovf <= 1'b0;
      else if (w_busy && w_last) r_ovf <= r_carry ^ w_co;
   end

   assign Ovf = r_ovf;
`endif

   assign busy = w_busy;
   assign done = w_done;
   assign Sum  = r_sum;
   assign Cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): table vectors, random vectors, corner sequences.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A, B;
   logic         Cin;
   logic         busy, done, Cout;
   logic [W-1:0] Sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic         Ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .Sum   (Sum),
      .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Reference: plain unsigned and signed arithmetic on the operands.
   function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b, input logic cin);
      int unsigned t;
      t = int'(a) + int'(b) + int'(cin);
      return t[8:0];
   endfunction

   function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b, input logic cin);
      int s;
      s = int'($signed(a)) + int'($signed(b)) + int'(cin);
      return (s > 127) || (s < -128);
   endfunction

   task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] esum, input logic ecout, input logic eovf,
                         input string name);
      int  n;
      int  busy_cnt;
      logic seen;
      @(negedge clk);
      A = a; B = b; Cin = cin; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
      n = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            if (busy) busy_cnt++;
            @(posedge clk);
            n++;
         end
      end
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
      chk({name, "_latency"}, 32'(n), 32'(W));
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({name, "_sum"}, 32'(Sum), 32'(esum));
      chk({name, "_cout"}, 32'(Cout), 32'(ecout));
`ifdef SERIAL_ADDER_OVF_EN
      chk({name, "_ovf"}, 32'(Ovf), 32'(eovf));
`endif
      @(negedge clk);
      chk({name, "_done_single"}, 32'(done), 32'd0);
      chk({name, "_sum_hold"}, 32'(Sum), 32'(esum));
   endtask

   vec_t tbl[7];

   initial begin
      logic [8:0] m;
      logic [7:0] ra, rb;
      logic       rc;
      int         pulses;
      int         last_c;
      int         c;
      logic [7:0] got_sum;

      tbl[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum", 32'(Sum), 32'd0);
      chk("reset_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset_ovf", 32'(Ovf), 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         do_add(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf,
                $sformatf("tbl%0d", i));

      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         m = model_sum(ra, rb, rc);
         do_add(ra, rb, rc, m[7:0], m[8], model_ovf(ra, rb, rc), $sformatf("rnd%0d", i));
      end

      // start while busy is ignored
      @(negedge clk);
      A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 8'hFF; B = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0; got_sum = '0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            got_sum = Sum;
            chk("ign_cout", 32'(Cout), 32'd0);
         end
      end
      chk("ign_pulses", 32'(pulses), 32'd1);
      chk("ign_sum", 32'(got_sum), 32'h30);

      // start held high: back-to-back results every WIDTH+1 cycles
      @(negedge clk);
      A = 8'h01; B = 8'h01; Cin = 1'b0; start = 1'b1;
      pulses = 0; last_c = -1; c = 0;
      while (pulses < 4 && c < 80) begin
         @(negedge clk);
         c++;
         if (done) begin
            chk("held_sum", 32'(Sum), 32'h02);
            if (last_c >= 0) chk("held_interval", 32'(c - last_c), 32'(W + 1));
            last_c = c;
            pulses++;
         end
      end
      start = 1'b0;
      chk("held_pulses", 32'(pulses), 32'd4);
      repeat (2) @(negedge clk);

      // reset in the middle of an operation
      do_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "pre_rst");
      @(negedge clk);
      A = 8'h01; B = 8'h02; Cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_sum", 32'(Sum), 32'd0);
      chk("midrst_cout", 32'(Cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);
      do_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1);
   end

endmodule
